// File: rtl/ins_fetch_unit_pkg.sv
// mips_defs: shared fetch constants, fetch state encoding and redirect-target helpers
//   RESET_PC      default PC of the first fetch after reset
//   OP_BEQ, OP_J  opcodes of the two redirecting instructions
//   fetch_state_e S_REQ (may issue a request) / S_WAIT (one request in flight)
//   branch_target, jump_target: redirect address computation, 32-bit modulo
package mips_defs;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010;
    typedef enum logic {S_REQ, S_WAIT} fetch_state_e;
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return (pc & ~32'd3) + 32'd4;
    endfunction
    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
        return pc_plus4(pc) + {{14{imm[15]}}, imm, 2'b00};
    endfunction
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
        logic [31:0] p4;
        p4 = pc_plus4(pc);
        return {p4[31:28], idx, 2'b00};
    endfunction
endpackage

// File: rtl/ins_fetch_unit_fetch_fifo.sv
// fetch_fifo: instruction buffer with flush and a head taken straight from the storage registers
//   push_i/data_i  write one entry (caller never pushes into a full FIFO without a pop)
//   pop_i          drop the head (ignored when empty)
//   flush_i        empty the FIFO; overrides push and pop
//   head_o/valid_o oldest entry and non-empty flag; count_o occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0] cnt_q;
    logic do_pop;
    assign do_pop = pop_i && cnt_q != '0;
    assign head_o = mem_q[rd_q];
    assign valid_o = cnt_q != '0;
    assign count_o = cnt_q;
    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= data_i;
            if (push_i) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: PC, single-outstanding imem fetch, instruction buffer and beq/j redirect
//   imem_*_o/_i       req/gnt address phase, in-order rvalid/rdata response
//   ins_valid_o/ready_i, instruction_o, ins_pc_o   decoder handshake on the FIFO head
//   redir_*_i         taken beq / j from execute; jump wins when both are set
module ins_fetch_unit #(
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] instruction_o,
    output logic [31:0] ins_pc_o,
    input  logic        redir_branch_i,
    input  logic        redir_jump_i,
    input  logic [31:0] redir_pc_i,
    input  logic [15:0] redir_imm16_i,
    input  logic [25:0] redir_imm26_i
);
    import mips_defs::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, target;
    logic req_q, req_d, discard_q, discard_d, redirect, hs, rsp, push, pop;
    logic [CW-1:0] count, count_d;
    logic [63:0] head;
    assign redirect = redir_branch_i | redir_jump_i;
    assign target = redir_jump_i ? jump_target(redir_pc_i, redir_imm26_i)
                                 : branch_target(redir_pc_i, redir_imm16_i);
    assign hs = req_q && imem_gnt_i;
    assign rsp = state_q == S_WAIT && imem_rvalid_i;
    assign push = rsp && !discard_q && !redirect;
    assign pop = ins_valid_o && ins_ready_i && !redirect;
    // Request is registered: it is raised only when the buffer will still have room
    // for the reply after this cycle's push/pop/flush.
    always_comb begin
        state_d = hs ? S_WAIT : rsp ? S_REQ : state_q;
        pc_d = redirect ? target : hs ? pc_q + 32'd4 : pc_q;
        discard_d = (redirect && (hs || (state_q == S_WAIT && !imem_rvalid_i))) ? 1'b1
                  : rsp ? 1'b0 : discard_q;
        count_d = redirect ? '0 : count + CW'(push) - CW'(pop);
        req_d = state_d == S_REQ && count_d < CW'(FIFO_DEPTH);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q <= RESET_PC;
            req_q <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_q <= req_d;
            discard_q <= discard_d;
        end
    end
    // A reply that is kept always belongs to pc_q-4: any redirect since the grant sets discard.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push_i(push),
        .pop_i(pop),
        .flush_i(redirect),
        .data_i({imem_rdata_i, pc_q - 32'd4}),
        .head_o(head),
        .valid_o(ins_valid_o),
        .count_o(count)
    );
    assign imem_req_o = req_q;
    assign imem_addr_o = pc_q;
    assign instruction_o = head[63:32];
    assign ins_pc_o = head[31:0];
endmodule
